regbank_wb_arbiter: RTL

//   Writeback arbiter + hazard scoreboard for the 16x32 register bank's single write port.
//   Two requesters (ALU result, memory load) compete; one winner per cycle drives o_dest/o_load/o_we.
//   Per-register busy bits, set at issue and cleared at writeback, give decode an RAW/WAW stall signal.

---
 rtl/regbank_wb_arbiter_pkg.sv | 24 ++
 rtl/regbank_scoreboard.sv | 47 ++++
 rtl/regbank_wb_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared constants and types for the register-bank writeback arbiter.
// Requester ids and the writeback payload struct live here so the top and scoreboard agree.
package regbank_wb_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NREG   = 2 ** ADDR_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Side that loses a contended grant to the given winner.
    function automatic req_id_e other_side(input req_id_e id);
        return (id == REQ_ALU) ? REQ_MEM : REQ_ALU;
    endfunction

endpackage : regbank_wb_arbiter_pkg

// File: rtl/regbank_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, set wins on collision.
// Provides the decode stall for two source operands and the issue-ready for one destination.
module regbank_scoreboard
    import regbank_wb_arbiter_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    output logic              clr_hit_c_o,
    input  logic [ADDR_W-1:0] chk1_i,
    input  logic [ADDR_W-1:0] chk2_i,
    output logic              stall_c_o,
    input  logic [ADDR_W-1:0] issue_idx_i,
    output logic              issue_ready_c_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear is applied first so a same-edge reservation of the same register survives.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // All lookups use the registered vector: a clear only becomes visible next cycle.
    assign clr_hit_c_o     = busy_q[clr_idx_i];
    assign stall_c_o       = busy_q[chk1_i] | busy_q[chk2_i];
    assign issue_ready_c_o = ~busy_q[issue_idx_i];

endmodule : regbank_scoreboard

// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter for the register bank's single write port, plus hazard scoreboard.
// Build option WB_ROUND_ROBIN_EN: round-robin on contention instead of fixed MEM-over-ALU.
module regbank_wb_arbiter
    import regbank_wb_arbiter_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              i_alu_valid,
    output logic              o_alu_ready,
    input  logic [ADDR_W-1:0] i_alu_dest,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [ADDR_W-1:0] i_mem_dest,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_dest,
    output logic              o_issue_ready,
    input  logic [ADDR_W-1:0] i_chk_r1,
    input  logic [ADDR_W-1:0] i_chk_r2,
    output logic              o_stall,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_dest,
    output logic [DATA_W-1:0] o_load,
    output logic              o_wb_err
);

    logic              open_q;
    logic              we_q;
    logic              we_d;
    logic [ADDR_W-1:0] dest_q;
    logic [ADDR_W-1:0] dest_d;
    logic [DATA_W-1:0] load_q;
    logic [DATA_W-1:0] load_d;
    logic              err_q;
    logic              err_d;

    logic              grant_c;
    logic              contended_c;
    req_id_e           grant_id_c;
    wb_req_t           sel_c;
    logic              clr_hit_c;
    logic              issue_ready_c;
    logic              issue_set_c;

`ifdef WB_ROUND_ROBIN_EN
    req_id_e           prio_q;
    req_id_e           prio_d;
`endif

    assign contended_c = i_alu_valid & i_mem_valid;

    // Pick a winner; open_q blocks any grant in the first cycle after reset release.
    always_comb begin
        grant_c    = open_q & (i_alu_valid | i_mem_valid);
        grant_id_c = REQ_ALU;
`ifdef WB_ROUND_ROBIN_EN
        if (contended_c) begin
            grant_id_c = prio_q;
        end else if (i_mem_valid) begin
            grant_id_c = REQ_MEM;
        end
`else
        if (i_mem_valid) begin
            grant_id_c = REQ_MEM;
        end
`endif
    end

    assign o_alu_ready = grant_c & (grant_id_c == REQ_ALU);
    assign o_mem_ready = grant_c & (grant_id_c == REQ_MEM);

    always_comb begin
        sel_c.dest = i_alu_dest;
        sel_c.data = i_alu_data;
        if (grant_id_c == REQ_MEM) begin
            sel_c.dest = i_mem_dest;
            sel_c.data = i_mem_data;
        end
    end

    assign issue_set_c   = i_issue_valid & issue_ready_c;
    assign o_issue_ready = issue_ready_c;

    regbank_scoreboard u_scoreboard (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .set_en_i        (issue_set_c),
        .set_idx_i       (i_issue_dest),
        .clr_en_i        (grant_c),
        .clr_idx_i       (sel_c.dest),
        .clr_hit_c_o     (clr_hit_c),
        .chk1_i          (i_chk_r1),
        .chk2_i          (i_chk_r2),
        .stall_c_o       (o_stall),
        .issue_idx_i     (i_issue_dest),
        .issue_ready_c_o (issue_ready_c)
    );

    // Output stage: one-cycle write pulse, address/data hold between writes.
    always_comb begin
        we_d   = grant_c;
        dest_d = dest_q;
        load_d = load_q;
        err_d  = err_q;
        if (grant_c) begin
            dest_d = sel_c.dest;
            load_d = sel_c.data;
            err_d  = err_q | ~clr_hit_c;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            open_q <= 1'b0;
            we_q   <= 1'b0;
            dest_q <= '0;
            load_q <= '0;
            err_q  <= 1'b0;
        end else begin
            open_q <= 1'b1;
            we_q   <= we_d;
            dest_q <= dest_d;
            load_q <= load_d;
            err_q  <= err_d;
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    // Favoured side flips only after a contended grant.
    always_comb begin
        prio_d = prio_q;
        if (grant_c && contended_c) begin
            prio_d = other_side(grant_id_c);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prio_q <= REQ_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign o_we     = we_q;
    assign o_dest   = dest_q;
    assign o_load   = load_q;
    assign o_wb_err = err_q;

endmodule : regbank_wb_arbiter
